// File: rtl/mem_dump_sequencer.sv
// Streams the data memory out over the debug UART: halts the pipeline, walks
// word addresses through the MEM-stage debug read port, and sends each word LSB first.
module mem_dump_sequencer #(
    parameter int          MEM_BYTES  = 256,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_req_halt,
    input  logic        i_halted,
    output logic [31:0] o_r_addr,
    input  logic [31:0] i_r_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_HALT = 3'd1,
        FETCH    = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [31:0] LAST_ADDR = START_ADDR + 32'(MEM_BYTES) - 32'd4;

    state_t      state;
    logic [31:0] word_q;
    logic [1:0]  byte_idx;
    logic        tx_fire;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    // Byte handshake: a byte moves on a rising clock edge where o_tx_valid and
    // i_tx_ready are both high. Once o_tx_valid rises, o_tx_data and o_tx_valid
    // hold until that edge; i_tx_ready may toggle freely in the meantime.
    assign tx_fire   = o_tx_valid && i_tx_ready;
    assign dbg_state = state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            o_r_addr   <= START_ADDR;
            o_req_halt <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            word_q     <= 32'h0;
            byte_idx   <= 2'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= REQ_HALT;
                        o_r_addr   <= START_ADDR;
                        byte_idx   <= 2'd0;
                        o_req_halt <= 1'b1;
                        o_busy     <= 1'b1;
                    end
                end
                REQ_HALT: begin
                    if (i_halted) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // The address has been stable for a full cycle here, so the async read has settled.
                    if (i_halted) begin
                        word_q     <= i_r_data;
                        o_tx_data  <= i_r_data[7:0];
                        o_tx_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx  <= byte_idx + 2'd1;
                            o_tx_data <= byte_of(word_q, byte_idx + 2'd1);
                        end else begin
                            byte_idx   <= 2'd0;
                            o_tx_valid <= 1'b0;
                            // Termination is tested before the increment, so the address never wraps.
                            if (o_r_addr == LAST_ADDR) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end else begin
                                o_r_addr <= o_r_addr + 32'd4;
                                state    <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    o_req_halt <= 1'b0;
                    o_busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed-plus-random bench for mem_dump_sequencer: memory model, byte scoreboard
// fed by a reference dump order computed from the memory contents.
module tb_mem_dump_sequencer;

    localparam int          MEM_BYTES  = 256;
    localparam int          WORDS      = MEM_BYTES / 4;
    localparam logic [31:0] START_ADDR = 32'h0;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_halted = 1'b0;
    logic        i_tx_ready = 1'b1;
    logic        o_req_halt;
    logic [31:0] o_r_addr;
    logic [31:0] i_r_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:WORDS-1];
    logic [7:0]  exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   bytes_seen = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;

    mem_dump_sequencer #(
        .MEM_BYTES (MEM_BYTES),
        .START_ADDR(START_ADDR)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .o_req_halt(o_req_halt),
        .i_halted  (i_halted),
        .o_r_addr  (o_r_addr),
        .i_r_data  (i_r_data),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .dbg_state (dbg_state)
    );

    // clock / memory model
    always #5 i_clk = ~i_clk;
    assign i_r_data = mem[o_r_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int w = 0; w < WORDS; w++) mem[w] = 32'hA500_0000 | 32'(w);
    endtask

    task automatic fill_random();
        for (int w = 0; w < WORDS; w++) mem[w] = $urandom;
    endtask

    // Reference: the dump is every word in address order, each as 4 bytes LSB first.
    task automatic build_expected();
        exp_q.delete();
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
        bytes_seen = 0;
        done_cnt   = 0;
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge i_clk);
        while (!o_done && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("done_seen", {31'b0, o_done}, 32'd1);
    endtask

    task automatic finish_dump(input int budget);
        wait_done(budget);
        @(negedge i_clk);
        check("bytes_total", bytes_seen, MEM_BYTES);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", {31'b0, o_busy}, 32'd0);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        do begin
            @(posedge i_clk);
            n++;
        end while (bytes_seen != target && n < 3000);
        check("reach_byte_count", bytes_seen, target);
    endtask

    // driver: ready pattern (0 = always ready, 1 = ready roughly one cycle in three)
    initial begin
        forever begin
            @(posedge i_clk);
            #1 i_tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    // scoreboard: accepted bytes against the reference queue, plus hold-while-stalled
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("tx_valid_held", {31'b0, o_tx_valid}, 32'd1);
                    check("tx_data_stable", {24'b0, o_tx_data}, {24'b0, held});
                end
                if (o_tx_valid && i_tx_ready) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_byte: observed=%0h expected=none", o_tx_data);
                    end else begin
                        check("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_q.pop_front()});
                    end
                end
                stalled = o_tx_valid && !i_tx_ready;
                held    = o_tx_data;
                if (o_done) done_cnt++;
            end
        end
    end

    initial begin
        int n;
        // reset state
        #2 i_reset = 1'b1;
        @(negedge i_clk);
        check("rst_r_addr", o_r_addr, START_ADDR);
        check("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
        check("rst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
        check("rst_req_halt", {31'b0, o_req_halt}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        @(posedge i_clk); #1 i_reset = 1'b0;

        // 1: pattern dump, always halted and ready, exact latency
        fill_pattern();
        build_expected();
        ready_mode = 0;
        i_halted   = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        check("req_halt_after_start", {31'b0, o_req_halt}, 32'd1);
        check("busy_after_start", {31'b0, o_busy}, 32'd1);
        n = 1;
        while (n < 1000) begin
            @(negedge i_clk);
            if (o_done) break;
            @(posedge i_clk);
            n++;
        end
        check("done_latency", n, 322);
        check("busy_during_done", {31'b0, o_busy}, 32'd1);
        check("last_addr", o_r_addr, START_ADDR + MEM_BYTES - 4);
        @(negedge i_clk);
        check("done_one_cycle", {31'b0, o_done}, 32'd0);
        check("busy_falls", {31'b0, o_busy}, 32'd0);
        check("req_halt_falls", {31'b0, o_req_halt}, 32'd0);
        check("addr_kept", o_r_addr, START_ADDR + MEM_BYTES - 4);
        check("bytes_total", bytes_seen, MEM_BYTES);
        check("done_pulses", done_cnt, 1);

        // 2: random data with back-pressure
        fill_random();
        build_expected();
        ready_mode = 1;
        pulse_start();
        finish_dump(4000);

        // 3: halt confirmation arrives late
        fill_random();
        build_expected();
        ready_mode = 0;
        i_halted   = 1'b0;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            check("req_halt_waiting", {31'b0, o_req_halt}, 32'd1);
            check("no_valid_unhalted", {31'b0, o_tx_valid}, 32'd0);
        end
        @(posedge i_clk); #1 i_halted = 1'b1;
        @(posedge i_clk); #1;
        check("valid_1_after_halt", {31'b0, o_tx_valid}, 32'd0);
        @(posedge i_clk); #1;
        check("valid_2_after_halt", {31'b0, o_tx_valid}, 32'd1);
        check("first_addr", o_r_addr, START_ADDR);
        finish_dump(2000);

        // 4: extra starts mid-dump and during DONE are ignored
        fill_random();
        build_expected();
        ready_mode = 1;
        pulse_start();
        repeat ($urandom_range(60, 200)) @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        wait_done(4000);
        i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("idle_after_done_start", {31'b0, o_busy}, 32'd0);
            check("no_valid_after_done", {31'b0, o_tx_valid}, 32'd0);
        end
        check("bytes_total_restart", bytes_seen, MEM_BYTES);
        check("exp_q_empty_restart", exp_q.size(), 0);
        check("done_pulses_restart", done_cnt, 1);

        // 5: async reset during word 5 byte 2, then a fresh dump from the start address
        fill_random();
        build_expected();
        ready_mode = 0;
        pulse_start();
        wait_bytes(22);
        #3 i_reset = 1'b1;
        #1;
        check("arst_r_addr", o_r_addr, START_ADDR);
        check("arst_tx_data", {24'b0, o_tx_data}, 32'd0);
        check("arst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
        check("arst_req_halt", {31'b0, o_req_halt}, 32'd0);
        check("arst_busy", {31'b0, o_busy}, 32'd0);
        check("arst_done", {31'b0, o_done}, 32'd0);
        @(posedge i_clk); #1 i_reset = 1'b0;
        fill_random();
        build_expected();
        pulse_start();
        check("restart_addr", o_r_addr, START_ADDR);
        check("restart_req_halt", {31'b0, o_req_halt}, 32'd1);
        finish_dump(2000);

        // 6: halt drops for 4 cycles while fetching word 9
        fill_random();
        build_expected();
        ready_mode = 0;
        pulse_start();
        wait_bytes(36);
        #1 i_halted = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check("fetch_hold_addr", o_r_addr, START_ADDR + 36);
            check("fetch_hold_no_valid", {31'b0, o_tx_valid}, 32'd0);
        end
        @(posedge i_clk); #1 i_halted = 1'b1;
        finish_dump(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
